// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter. Each byte is sent as inhibit, then request-to-send,
// then bits shifted on device clock edges, then ACK check. A timeout aborts a stalled device.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int TIMEOUT_CYCLES = 1500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_ok,
    output logic       timeout_err
);
    localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_RTS,
        S_SHIFT,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [1:0]         line_raw;
    logic [1:0]         sync_p0;
    logic [1:0]         sync_p1;
    logic [1:0]         filt;
    logic [1:0]         filt_cnt [2];
    logic               filt_clk_q;
    logic               clk_fall;

    logic [9:0]         frame_q;
    logic [3:0]         bit_idx;
    logic [INH_W-1:0]   inh_cnt;
    logic [TO_W-1:0]    to_cnt;
    logic               data_oe_q;
    logic               done_q;
    logic               ack_q;
    logic               terr_q;

    logic               accept;
    logic               inh_last;
    logic               timeout_hit;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~(^d);
    endfunction

    // Line stage: two-flop synchronizer, then a 4-sample agreement filter per line
    assign line_raw = {ps2_data_in, ps2_clk_in};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0     <= 2'b11;
            sync_p1     <= 2'b11;
            filt        <= 2'b11;
            filt_clk_q  <= 1'b1;
            filt_cnt[0] <= 2'd0;
            filt_cnt[1] <= 2'd0;
        end else begin
            sync_p0    <= line_raw;
            sync_p1    <= sync_p0;
            filt_clk_q <= filt[0];
            for (int i = 0; i < 2; i++) begin
                if (sync_p1[i] == filt[i]) begin
                    filt_cnt[i] <= 2'd0;
                end else if (filt_cnt[i] == 2'd3) begin
                    filt[i]     <= sync_p1[i];
                    filt_cnt[i] <= 2'd0;
                end else begin
                    filt_cnt[i] <= filt_cnt[i] + 2'd1;
                end
            end
        end
    end

    assign clk_fall    = filt_clk_q & ~filt[0];
    assign accept      = tx_valid && (state == S_IDLE);
    assign inh_last    = (inh_cnt == INH_W'(INHIBIT_CYCLES - 1));
    assign timeout_hit = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    // Frame stage: data bits LSB first, then parity, then stop
    always_ff @(posedge clk) begin
        if (accept) begin
            frame_q <= {1'b1, odd_parity(tx_data), tx_data};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (accept) state_nxt = S_INHIBIT;
            S_INHIBIT:   if (inh_last) state_nxt = S_RTS;
            S_RTS:       if (timeout_hit) state_nxt = S_IDLE;
                         else if (clk_fall) state_nxt = S_SHIFT;
            S_SHIFT:     if (timeout_hit) state_nxt = S_IDLE;
                         else if (clk_fall && bit_idx == 4'd9) state_nxt = S_ACK;
            S_ACK:       if (timeout_hit) state_nxt = S_IDLE;
                         else if (clk_fall) state_nxt = S_WAIT_IDLE;
            S_WAIT_IDLE: if (filt == 2'b11) state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    // Transfer stage: counters, presented bit and status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inh_cnt   <= '0;
            to_cnt    <= '0;
            bit_idx   <= 4'd0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b0;
            ack_q     <= 1'b0;
            terr_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        inh_cnt   <= '0;
                        to_cnt    <= '0;
                        bit_idx   <= 4'd0;
                        data_oe_q <= 1'b0;
                        ack_q     <= 1'b0;
                        terr_q    <= 1'b0;
                    end
                end
                S_INHIBIT: begin
                    inh_cnt <= inh_cnt + 1'b1;
                    if (inh_last) begin
                        data_oe_q <= 1'b1;
                    end
                end
                S_RTS, S_SHIFT, S_ACK: begin
                    to_cnt <= to_cnt + 1'b1;
                    if (timeout_hit) begin
                        data_oe_q <= 1'b0;
                        done_q    <= 1'b1;
                        terr_q    <= 1'b1;
                        ack_q     <= 1'b0;
                    end else if (clk_fall) begin
                        if (state == S_ACK) begin
                            ack_q <= ~filt[1];
                        end else begin
                            data_oe_q <= ~frame_q[bit_idx];
                            bit_idx   <= bit_idx + 4'd1;
                        end
                    end
                end
                S_WAIT_IDLE: begin
                    if (filt == 2'b11) begin
                        done_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy        = (state != S_IDLE);
        tx_ready    = (state == S_IDLE);
        ps2_clk_oe  = (state == S_INHIBIT);
        ps2_data_oe = ((state == S_RTS) || (state == S_SHIFT)) && data_oe_q;
        done        = done_q;
        ack_ok      = ack_q;
        timeout_err = terr_q;
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device clocks the host's frame out,
// and each captured frame is compared with one built from the byte value.
module tb_ps2_host_tx;
    localparam int INH = 200;
    localparam int TO  = 5000;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       busy;
    logic       done;
    logic       ack_ok;
    logic       timeout_err;
    logic       dev_clk;
    logic       dev_data;

    int total    = 0;
    int bad      = 0;
    int cyc      = 0;
    int done_cnt = 0;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .busy        (busy),
        .done        (done),
        .ack_ok      (ack_ok),
        .timeout_err (timeout_err)
    );

    // Open-drain bus: a line is low if either side pulls it low
    assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_in = dev_data & ~ps2_data_oe;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

    // Reference frame: 8 data bits LSB first, odd parity, stop bit 1
    function automatic logic [9:0] expected_frame(input logic [7:0] d);
        logic par;
        par = (($countones(d) % 2) == 0);
        return {1'b1, par, d};
    endfunction

    task automatic send_byte(input logic [7:0] d);
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
    endtask

    task automatic wait_rts(output int inh_len, output bit ok);
        inh_len = 0;
        ok      = 1'b0;
        for (int i = 0; i < INH + 100; i++) begin
            @(negedge clk);
            if (ps2_clk_oe === 1'b1) inh_len++;
            else if (inh_len > 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Device: n clock pulses of half-period h; samples data at the end of each high phase
    task automatic device(input int n, input int h, input bit ack, input bit glitch,
                          output logic [9:0] bits);
        bits = '0;
        repeat (h) @(negedge clk);
        for (int p = 1; p <= n; p++) begin
            if (p == 11 && ack) begin
                dev_data = 1'b0;
                repeat (h) @(negedge clk);
            end
            for (int c = 0; c < h; c++) begin
                dev_clk = (glitch && p >= 2 && p <= 10 && c >= h / 2 && c < h / 2 + 2);
                @(negedge clk);
            end
            for (int c = 0; c < h; c++) begin
                dev_clk = !(glitch && p >= 2 && p <= 10 && c >= h / 2 && c < h / 2 + 2);
                @(negedge clk);
            end
            if (p <= 10) bits[p-1] = ps2_data_in;
        end
        dev_clk = 1'b1;
        repeat (h) @(negedge clk);
        dev_data = 1'b1;
    endtask

    task automatic do_xfer(input logic [7:0] d, input int h, input bit ack, input bit glitch,
                           input bit inject);
        int         inh_len;
        int         dc0;
        bit         ok;
        logic [9:0] bits;
        dc0 = done_cnt;
        send_byte(d);
        wait_rts(inh_len, ok);
        total++;
        if (!ok || inh_len != INH) begin
            bad++;
            $display("FAIL inhibit_len byte=%02h: got %0d want %0d", d, inh_len, INH);
        end
        total++;
        if (ps2_data_oe !== 1'b1) begin
            bad++;
            $display("FAIL start_bit byte=%02h: data_oe got %b want 1", d, ps2_data_oe);
        end
        fork
            device(11, h, ack, glitch, bits);
            begin
                if (inject) begin
                    repeat (4 * h) @(negedge clk);
                    tx_data  = 8'hAA;
                    tx_valid = 1'b1;
                    @(negedge clk);
                    tx_valid = 1'b0;
                end
            end
        join
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        repeat (5) @(negedge clk);
        total++;
        if (bits !== expected_frame(d)) begin
            bad++;
            $display("FAIL frame byte=%02h: got %03h want %03h", d, bits, expected_frame(d));
        end
        total++;
        if (!ok || (done_cnt - dc0) != 1) begin
            bad++;
            $display("FAIL done_count byte=%02h: got %0d want 1 (idle=%0d)", d, done_cnt - dc0, ok);
        end
        total++;
        if (ack_ok !== ack || timeout_err !== 1'b0) begin
            bad++;
            $display("FAIL status byte=%02h: ack_ok=%b terr=%b want ack_ok=%b terr=0",
                     d, ack_ok, timeout_err, ack);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++;
        if ({ps2_clk_oe, ps2_data_oe, busy, done, ack_ok, timeout_err, tx_ready} !== 7'b0000001) begin
            bad++;
            $display("FAIL reset_held: got %b want 0000001",
                     {ps2_clk_oe, ps2_data_oe, busy, done, ack_ok, timeout_err, tx_ready});
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({ps2_clk_oe, ps2_data_oe, busy, done, ack_ok, timeout_err, tx_ready} !== 7'b0000001) begin
            bad++;
            $display("FAIL reset_release: got %b want 0000001",
                     {ps2_clk_oe, ps2_data_oe, busy, done, ack_ok, timeout_err, tx_ready});
        end
    endtask

    task automatic test_ack();
        do_xfer(8'hF4, 20, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_no_ack();
        do_xfer(8'hED, 20, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_timeout();
        int inh_len;
        int c_e;
        int waited;
        bit ok;
        send_byte(8'hFF);
        wait_rts(inh_len, ok);
        c_e    = cyc;
        waited = -1;
        for (int i = 0; i < TO + 200; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                waited = cyc - c_e;
                break;
            end
        end
        total++;
        if (waited != TO) begin
            bad++;
            $display("FAIL timeout_latency: got %0d want %0d", waited, TO);
        end
        total++;
        if ({timeout_err, ack_ok, ps2_clk_oe, ps2_data_oe} !== 4'b1000) begin
            bad++;
            $display("FAIL timeout_status: got %b want 1000",
                     {timeout_err, ack_ok, ps2_clk_oe, ps2_data_oe});
        end
        repeat (30) @(negedge clk);
        total++;
        if ({timeout_err, tx_ready} !== 2'b11) begin
            bad++;
            $display("FAIL timeout_hold: got %b want 11", {timeout_err, tx_ready});
        end
    endtask

    task automatic test_glitch();
        do_xfer(8'h01, 20, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid();
        int         inh_len;
        int         dc0;
        bit         ok;
        logic [9:0] bits;
        dc0 = done_cnt;
        send_byte(8'h05);
        wait_rts(inh_len, ok);
        device(5, 16, 1'b0, 1'b0, bits);
        total++;
        if (bits[4:0] !== 5'b00101 || ps2_data_oe !== 1'b1) begin
            bad++;
            $display("FAIL partial_frame: got %b oe=%b want 00101 oe=1", bits[4:0], ps2_data_oe);
        end
        rst = 1'b1;
        #1;
        total++;
        if ({ps2_clk_oe, ps2_data_oe, busy} !== 3'b000) begin
            bad++;
            $display("FAIL async_release: got %b want 000", {ps2_clk_oe, ps2_data_oe, busy});
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        total++;
        if (done_cnt != dc0) begin
            bad++;
            $display("FAIL reset_no_done: got %0d pulses want 0", done_cnt - dc0);
        end
        do_xfer(8'h00, 20, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_busy_ignore();
        do_xfer(8'h3C, 20, 1'b1, 1'b0, 1'b1);
        repeat (INH) @(negedge clk);
        total++;
        if ({ps2_clk_oe, busy, tx_ready} !== 3'b001) begin
            bad++;
            $display("FAIL busy_ignored: got %b want 001", {ps2_clk_oe, busy, tx_ready});
        end
    endtask

    task automatic test_random();
        logic [7:0] d;
        int         h;
        bit         a;
        for (int i = 0; i < 6; i++) begin
            d = 8'($urandom_range(0, 255));
            h = $urandom_range(12, 30);
            a = 1'($urandom_range(0, 1));
            do_xfer(d, h, a, 1'b0, 1'b0);
        end
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    initial begin
        rst      = 1'b0;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        #2;
        rst = 1'b1;
        test_reset();
        test_ack();
        test_no_ack();
        test_timeout();
        test_glitch();
        test_reset_mid();
        test_busy_ignore();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, default 10000, clk cycles the PS/2 clock is held low before request-to-send (100 us at 100 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1500000, maximum clk cycles from request-to-send to acknowledge (15 ms).
REQ-003 SHALL have port clk  in  1  system clock, all logic on rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port tx_data  in  8  command byte to send to the keyboard.
REQ-006 SHALL have port tx_valid  in  1  request; the byte is accepted when tx_valid and tx_ready are both 1.
REQ-007 SHALL have port tx_ready  out  1  block idle, ready to accept a byte.
REQ-008 SHALL have port ps2_clk_in  in  1  raw PS2_CLK line level.
REQ-009 SHALL have port ps2_data_in  in  1  raw PS2_DATA line level.
REQ-010 SHALL have port ps2_clk_oe  out  1  1 = drive PS2_CLK low; 0 = release (top level ties the line to high-Z).
REQ-011 SHALL have port ps2_data_oe  out  1  1 = drive PS2_DATA low; 0 = release.
REQ-012 SHALL have port busy  out  1  transfer in progress; top level uses it to gate the keyboard receiver.
REQ-013 SHALL have port done  out  1  one-cycle pulse at transfer end.
REQ-014 SHALL have port ack_ok  out  1  valid with done; 1 = device acknowledged.
REQ-015 SHALL have port timeout_err  out  1  valid with done; 1 = transfer aborted by timeout.

Function
REQ-016 SHALL synchronize both line inputs through 2 flops, then filter each one: the filtered level changes only after 4 consecutive equal synchronized samples.
REQ-017 SHALL detect a PS/2 clock falling edge as a filtered 1->0 transition, lasting one clk cycle.
REQ-018 SHALL implement states IDLE, INHIBIT, RTS, SHIFT, ACK, WAIT_IDLE.
REQ-019 IDLE: tx_ready=1, both oe=0; on accept, SHALL latch tx_data, compute odd parity (parity = NOT XOR-reduce of data), clear counters, and go to INHIBIT.
REQ-020 INHIBIT: ps2_clk_oe=1 for exactly INHIBIT_CYCLES cycles; in the last cycle SHALL set ps2_data_oe=1 (start bit) and go to RTS.
REQ-021 RTS: ps2_clk_oe=0, ps2_data_oe=1; on the first falling edge, SHALL drive data bit 0 (ps2_data_oe = NOT bit) and go to SHIFT with bit index 1.
REQ-022 SHIFT: on each falling edge SHALL present the next bit, LSB first: data[1..7], then parity, then stop (ps2_data_oe=0); after the edge that presents stop, go to ACK.
REQ-023 ACK: on the next falling edge SHALL sample filtered data; 0 gives ack_ok=1, 1 gives ack_ok=0; then go to WAIT_IDLE.
REQ-024 WAIT_IDLE: SHALL wait until both filtered lines are 1, then pulse done for one cycle and return to IDLE.
REQ-025 Timeout counter SHALL run from entry to RTS until leaving ACK; reaching TIMEOUT_CYCLES SHALL release both lines, pulse done with timeout_err=1 and ack_ok=0, and go to IDLE.
REQ-026 Falling edges in IDLE and INHIBIT SHALL be ignored.
REQ-027 tx_valid while busy SHALL be ignored; no queueing.
REQ-028 busy=1 in every state except IDLE; tx_ready = NOT busy.
REQ-029 ack_ok and timeout_err SHALL hold their values until the next accept; done is 1 for exactly one cycle per accepted byte.
REQ-030 Output encoding: ps2_data_oe=1 exactly when the bit currently presented is 0; the parity and stop positions follow the same rule.

Reset
REQ-031 On rst: state=IDLE; ps2_clk_oe=0, ps2_data_oe=0, busy=0, done=0, ack_ok=0, timeout_err=0, tx_ready=1; counters, filter and synchronizer flops set to 1/idle.
REQ-032 rst asserted mid-transfer SHALL release both lines immediately (asynchronously) and produce no done pulse.

Verification
REQ-033 Send 0xF4 with a device model that clocks at 12.5 kHz and ACKs -> clk held low for 10000 cycles; data bits 0,0,1,0,1,1,1,1; parity 0; stop 1; done with ack_ok=1 and timeout_err=0.
REQ-034 Send 0xED, device omits ACK (data stays high) -> bit sequence 1,0,1,1,0,1,1,1, parity 1; done with ack_ok=0 and timeout_err=0.
REQ-035 Set TIMEOUT_CYCLES=5000, send 0xFF, device never clocks -> done at 5000 cycles after RTS entry, timeout_err=1, both oe=0.
REQ-036 Inject 2-cycle glitches on ps2_clk_in during SHIFT of byte 0x01 -> no extra bits; parity 0 transmitted; ack_ok=1.
REQ-037 Assert rst during SHIFT bit 4 -> ps2_clk_oe=0 and ps2_data_oe=0 in the same cycle; no done pulse; a following 0x00 transfer completes with parity 1.
REQ-038 Pulse tx_valid with 0xAA during busy -> ignored; only the first byte is sent; exactly one done pulse.
